// File: rtl/fb_bank_scheduler.sv
// Triple-buffer bank scheduler: rotates write/ready/display banks only at frame
// boundaries and prefixes the bank index onto the shared frame-RAM addresses.
module fb_bank_scheduler #(
    parameter int unsigned ADDR_W      = 16,
    parameter int unsigned DATA_W      = 15,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_wr_vs,
    input  logic              i_rd_vs,
    input  logic              i_wre,
    input  logic [ADDR_W-1:0] i_wraddr,
    input  logic [DATA_W-1:0] i_data,
    input  logic [ADDR_W-1:0] i_rdaddr,
    output logic              o_wre,
    output logic [ADDR_W+1:0] o_wraddr,
    output logic [DATA_W-1:0] o_data,
    output logic [ADDR_W+1:0] o_rdaddr,
    output logic [1:0]        o_wbank,
    output logic [1:0]        o_dbank,
    output logic              o_fresh,
    output logic              o_armed,
    output logic [CNT_W-1:0]  o_drop_cnt,
    output logic [CNT_W-1:0]  o_rep_cnt
);

    typedef enum logic {StIdle, StRun} state_t;

    state_t                 r_state;
    logic [SYNC_STAGES-1:0] r_wr_sync, r_rd_sync;
    logic                   r_wr_prev, r_rd_prev;
    logic                   r_wr_ev, r_rd_ev;
    logic [1:0]             r_wbank, r_rbank, r_dbank;
    logic                   r_fresh;
    logic [CNT_W-1:0]       r_drop_cnt, r_rep_cnt;
    logic                   r_wre;
    logic [ADDR_W+1:0]      r_wraddr, r_rdaddr;
    logic [DATA_W-1:0]      r_data;

    logic w_wr_s, w_rd_s, w_drop_sat, w_rep_sat;

    assign w_wr_s     = r_wr_sync[SYNC_STAGES-1];
    assign w_rd_s     = r_rd_sync[SYNC_STAGES-1];
    assign w_drop_sat = &r_drop_cnt;
    assign w_rep_sat  = &r_rep_cnt;

    // Synchronisers plus registered rising-edge pulses.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wr_sync <= '0;
            r_rd_sync <= '0;
            r_wr_prev <= 1'b0;
            r_rd_prev <= 1'b0;
            r_wr_ev   <= 1'b0;
            r_rd_ev   <= 1'b0;
        end else begin
            r_wr_sync <= (r_wr_sync << 1) | SYNC_STAGES'(i_wr_vs);
            r_rd_sync <= (r_rd_sync << 1) | SYNC_STAGES'(i_rd_vs);
            r_wr_prev <= w_wr_s;
            r_rd_prev <= w_rd_s;
            r_wr_ev   <= w_wr_s & ~r_wr_prev;
            r_rd_ev   <= w_rd_s & ~r_rd_prev;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state    <= StIdle;
            r_wbank    <= 2'd0;
            r_rbank    <= 2'd1;
            r_dbank    <= 2'd2;
            r_fresh    <= 1'b0;
            r_drop_cnt <= '0;
            r_rep_cnt  <= '0;
        end else if (i_enable) begin
            case (r_state)
                StIdle: begin
                    if (r_wr_ev) r_state <= StRun;
                end
                StRun: begin
                    if (r_wr_ev && r_rd_ev) begin
                        // Reader takes the just-finished frame directly.
                        r_dbank <= r_wbank;
                        r_wbank <= r_rbank;
                        r_rbank <= r_dbank;
                        r_fresh <= 1'b0;
                        if (r_fresh && !w_drop_sat) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end else if (r_wr_ev) begin
                        r_wbank <= r_rbank;
                        r_rbank <= r_wbank;
                        r_fresh <= 1'b1;
                        if (r_fresh && !w_drop_sat) r_drop_cnt <= r_drop_cnt + CNT_W'(1);
                    end else if (r_rd_ev) begin
                        if (r_fresh) begin
                            r_dbank <= r_rbank;
                            r_rbank <= r_dbank;
                            r_fresh <= 1'b0;
                        end else if (!w_rep_sat) begin
                            r_rep_cnt <= r_rep_cnt + CNT_W'(1);
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Address/data pipeline runs regardless of i_enable.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wre    <= 1'b0;
            r_wraddr <= '0;
            r_data   <= '0;
            r_rdaddr <= '0;
        end else begin
            r_wre    <= i_wre & (r_state == StRun);
            r_wraddr <= {r_wbank, i_wraddr};
            r_data   <= i_data;
            r_rdaddr <= {r_dbank, i_rdaddr};
        end
    end

    assign o_wre      = r_wre;
    assign o_wraddr   = r_wraddr;
    assign o_data     = r_data;
    assign o_rdaddr   = r_rdaddr;
    assign o_wbank    = r_wbank;
    assign o_dbank    = r_dbank;
    assign o_fresh    = r_fresh;
    assign o_armed    = (r_state == StRun);
    assign o_drop_cnt = r_drop_cnt;
    assign o_rep_cnt  = r_rep_cnt;

endmodule
